// File: rtl/cp0_timer_ctrl_if.sv
// Bus between the M stage / interrupt bridge and coprocessor 0.
// The pipeline side drives the master modport and CP0 uses the slave modport.
interface cp0_timer_ctrl_if #(
  parameter int HW_INT_N = 6
);
  logic                we;
  logic [4:0]          addr;
  logic [31:0]         wdata;
  logic [31:0]         rdata;
  logic [31:0]         vpc;
  logic                bd_in;
  logic [4:0]          exc_code_in;
  logic [31:0]         bad_vaddr_in;
  logic [HW_INT_N-1:0] hw_int;
  logic                eret;
  logic [31:0]         epc_out;
  logic                req;
  logic                timer_irq;

  modport master (
    output we, addr, wdata, vpc, bd_in, exc_code_in, bad_vaddr_in, hw_int, eret,
    input  rdata, epc_out, req, timer_irq
  );

  modport slave (
    input  we, addr, wdata, vpc, bd_in, exc_code_in, bad_vaddr_in, hw_int, eret,
    output rdata, epc_out, req, timer_irq
  );
endinterface

// File: rtl/cp0_timer_ctrl.sv
// Coprocessor 0 for the pipelined MIPS core: SR, Cause, EPC, BadVAddr,
// Count/Compare timer and PRId. Raises req in the same cycle an exception or
// unmasked interrupt is seen at M, and forwards the exception PC on epc_out.
module cp0_timer_ctrl #(
  parameter int          HW_INT_N = 6,
  parameter int          TIMER_EN = 1,
  parameter logic [31:0] PRID_VAL = 32'h0023_0700
) (
  input logic             clk,
  input logic             reset,
  cp0_timer_ctrl_if.slave bus
);

  localparam bit TMR = (TIMER_EN != 0);

  logic [7:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic        cause_ti;
  logic [7:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;

  logic [7:0]  ip_vec;
  logic        int_req;
  logic        exc_req;
  logic        req_c;
  logic [31:0] epc_fwd;
  logic        wr_ok;
  logic        ti_set;
  logic        ti_clr;

  // Pending-interrupt vector: external lines low, timer on the top bit.
  always_comb begin
    ip_vec                 = 8'h00;
    ip_vec[HW_INT_N-1:0]   = bus.hw_int;
    if (TMR) ip_vec[7]     = cause_ti;
  end

  // Exception/interrupt decision and write acceptance; req beats eret beats mtc0.
  always_comb begin
    int_req = sr_ie & ~sr_exl & (|(sr_im & ip_vec));
    exc_req = ~sr_exl & (bus.exc_code_in != 5'd0);
    req_c   = int_req | exc_req;
    epc_fwd = req_c ? (bus.bd_in ? (bus.vpc - 32'd4) : bus.vpc) : epc_q;
    wr_ok   = bus.we & ~req_c & ~bus.eret;
    ti_set  = TMR && (count_q == compare_q);
    ti_clr  = TMR && wr_ok && (bus.addr == 5'd11);
  end

  // Status, cause, EPC and BadVAddr updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im      <= 8'h00;
      sr_exl     <= 1'b0;
      sr_ie      <= 1'b0;
      cause_bd   <= 1'b0;
      cause_ip   <= 8'h00;
      cause_exc  <= 5'd0;
      epc_q      <= 32'h0;
      badvaddr_q <= 32'h0;
    end else begin
      cause_ip <= ip_vec;
      if (req_c) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bus.bd_in;
        cause_exc <= int_req ? 5'd0 : bus.exc_code_in;
        epc_q     <= epc_fwd;
        if (!int_req && (bus.exc_code_in == 5'd4 || bus.exc_code_in == 5'd5))
          badvaddr_q <= bus.bad_vaddr_in;
      end else if (bus.eret) begin
        sr_exl <= 1'b0;
      end else if (bus.we) begin
        case (bus.addr)
          5'd12: begin
            sr_im  <= bus.wdata[15:8];
            sr_exl <= bus.wdata[1];
            sr_ie  <= bus.wdata[0];
          end
          5'd14:   epc_q <= bus.wdata;
          default: ;
        endcase
      end
    end
  end

  // Free-running Count, Compare, and the sticky timer flag (clear beats set).
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= 32'h0;
      compare_q <= 32'hFFFF_FFFF;
      cause_ti  <= 1'b0;
    end else if (TMR) begin
      count_q <= (wr_ok && bus.addr == 5'd9) ? bus.wdata : count_q + 32'd1;
      if (ti_clr) compare_q <= bus.wdata;
      cause_ti <= ti_clr ? 1'b0 : (cause_ti | ti_set);
    end
  end

  // mfc0 read mux; unmapped registers and an absent timer read as zero.
  always_comb begin
    case (bus.addr)
      5'd8:    bus.rdata = badvaddr_q;
      5'd9:    bus.rdata = TMR ? count_q : 32'h0;
      5'd11:   bus.rdata = TMR ? compare_q : 32'h0;
      5'd12:   bus.rdata = {16'h0, sr_im, 6'h0, sr_exl, sr_ie};
      5'd13:   bus.rdata = {cause_bd, cause_ti, 14'h0, cause_ip, 1'b0, cause_exc, 2'b00};
      5'd14:   bus.rdata = epc_q;
      5'd15:   bus.rdata = PRID_VAL;
      default: bus.rdata = 32'h0;
    endcase
  end

  assign bus.req       = req_c;
  assign bus.epc_out   = epc_fwd;
  assign bus.timer_irq = cause_ti;

endmodule
